// File: rtl/datapath_run_ctrl.sv
// datapath_run_ctrl: clock-enable run control (halt/run/step/breakpoint/fault) with divider and perf counters
module datapath_run_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [1:0]              Mode,
  input  logic                    StepReq,
  input  logic [DIV_W-1:0]        DivSel,
  input  logic [NUM_BP*WIDTH-1:0] BpAddr,
  input  logic [NUM_BP-1:0]       BpEn,
  input  logic [WIDTH-1:0]        PC,
  input  logic                    PCWriteOut,
  input  logic                    MemOutOfBounds,
  output logic                    CE,
  output logic                    Halted,
  output logic [2:0]              HaltCause,
  output logic [CNT_W-1:0]        CycleCount,
  output logic [CNT_W-1:0]        InstrCount
);
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_FAULT} state_t;
  state_t state, state_n;
  logic [2:0] cause_n;
  logic [DIV_W-1:0] div_cnt, div_lim;
  logic boundary, bp_hit, bp_kill, active, wrap, retire, fault, enter;
  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++)
      if (BpEn[i] && PC == BpAddr[i*WIDTH +: WIDTH]) bp_hit = 1'b1;
  end
  assign active  = state == S_RUN || state == S_STEP;
  assign wrap    = div_cnt == div_lim;
  assign bp_kill = state == S_RUN && Mode == 2'b11 && boundary && bp_hit;
  assign CE      = active && wrap && !bp_kill;
  assign retire  = CE && PCWriteOut;
  assign fault   = CE && MemOutOfBounds;
  assign enter   = state == S_HALT && state_n != S_HALT;
  assign Halted  = state == S_HALT || state == S_FAULT;
  always_comb begin
    state_n = state;
    cause_n = HaltCause;
    case (state)
      S_HALT:
        if (Mode[0]) begin
          state_n = S_RUN;
          cause_n = 3'b000;
        end else if (Mode == 2'b10 && StepReq) begin
          state_n = S_STEP;
          cause_n = 3'b000;
        end
      S_RUN:
        if (fault) begin
          state_n = S_FAULT;
          cause_n = 3'b100;
        end else if (bp_kill) begin
          state_n = S_HALT;
          cause_n = 3'b010;
        end else if (!Mode[0]) begin
          state_n = S_HALT;
          cause_n = 3'b001;
        end
      S_STEP:
        if (fault) begin
          state_n = S_FAULT;
          cause_n = 3'b100;
        end else if (retire) begin
          state_n = S_HALT;
          cause_n = 3'b011;
        end else if (Mode == 2'b00) begin
          state_n = S_HALT;
          cause_n = 3'b001;
        end
      default:
        state_n = Mode == 2'b00 ? S_HALT : S_FAULT;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= S_HALT;
      HaltCause  <= 3'b000;
      div_cnt    <= '0;
      div_lim    <= '0;
      boundary   <= 1'b0;
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      state     <= state_n;
      HaltCause <= cause_n;
      if (enter || (active && wrap)) begin
        div_cnt <= '0;
        div_lim <= DivSel;
      end else if (active) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // clearing on resume lets a halted breakpoint instruction execute
      boundary   <= enter ? 1'b0 : retire ? 1'b1 : CE ? 1'b0 : boundary;
      CycleCount <= CycleCount + CNT_W'(CE);
      InstrCount <= InstrCount + CNT_W'(retire);
    end
  end
endmodule

// File: tb/tb_datapath_run_ctrl.sv
// tb_datapath_run_ctrl: directed checks of run control with a 4-CE-per-instruction datapath stand-in
module tb_datapath_run_ctrl;
  logic        clk, rst_n, step_req, pcw, oob, ce, halted;
  logic [1:0]  mode;
  logic [7:0]  div_sel;
  logic [31:0] bp_addr;
  logic [1:0]  bp_en;
  logic [15:0] pc;
  logic [2:0]  cause;
  logic [31:0] cyc_cnt, ins_cnt;
  int checks, errors, ce_n, phase;
  logic ce_s;
  logic [7:0] pat;

  datapath_run_ctrl dut (
    .CLK(clk), .Reset(rst_n), .Mode(mode), .StepReq(step_req), .DivSel(div_sel),
    .BpAddr(bp_addr), .BpEn(bp_en), .PC(pc), .PCWriteOut(pcw), .MemOutOfBounds(oob),
    .CE(ce), .Halted(halted), .HaltCause(cause), .CycleCount(cyc_cnt), .InstrCount(ins_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: datapath advances a phase on each CE, retiring every 4th and stepping PC by 2
  task automatic tick();
    #1;
    ce_s = ce;
    @(posedge clk);
    #1;
    if (ce_s) begin
      ce_n++;
      if (phase == 3) begin
        phase = 0;
        pc = pc + 16'd2;
      end else phase++;
    end
    pcw = (phase == 3);
    pat = {pat[6:0], ce_s};
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mode = 2'b00;
    step_req = 1'b0;
    oob = 1'b0;
    pc = '0;
    pcw = 1'b0;
    phase = 0;
    ce_n = 0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; pat = '0;
    div_sel = '0; bp_addr = '0; bp_en = '0;
    do_reset();
    chk("reset_ce", ce, 0);
    chk("reset_halted", halted, 1);
    chk("reset_cause", cause, 0);
    chk("reset_cyc", cyc_cnt, 0);
    chk("reset_ins", ins_cnt, 0);

    mode = 2'b01;
    tick();
    chk("run_first_ce", ce, 1);
    repeat (99) tick();
    mode = 2'b00;
    tick();
    chk("run_ce_seen", ce_n, 100);
    chk("run_cyc", cyc_cnt, 100);
    chk("run_ins", ins_cnt, 25);
    chk("run_user_halt", halted, 1);
    chk("run_user_cause", cause, 3'b001);
    chk("run_halt_ce", ce, 0);

    do_reset();
    div_sel = 8'd3;
    mode = 2'b01;
    tick();
    pat = '0;
    repeat (8) tick();
    chk("div3_pattern", pat, 8'b0001_0001);
    div_sel = 8'd1;
    repeat (8) tick();
    chk("div_change_pattern", pat, 8'b0001_0101);
    chk("div_cyc", cyc_cnt, 5);

    do_reset();
    div_sel = 8'd0;
    mode = 2'b10;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ce_n = 0;
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (4) tick();
    chk("step_ce_pulses", ce_n, 4);
    chk("step_ins", ins_cnt, 1);
    chk("step_cyc", cyc_cnt, 4);
    chk("step_halted", halted, 1);
    chk("step_cause", cause, 3'b011);

    do_reset();
    bp_addr = {16'h0100, 16'h0006};
    bp_en = 2'b01;
    mode = 2'b11;
    tick();
    ce_n = 0;
    repeat (12) tick();
    chk("bp_pc", pc, 16'h0006);
    chk("bp_no_ce", ce, 0);
    tick();
    mode = 2'b00;
    chk("bp_halted", halted, 1);
    chk("bp_cause", cause, 3'b010);
    chk("bp_ce_seen", ce_n, 12);
    chk("bp_cyc", cyc_cnt, 12);
    chk("bp_ins", ins_cnt, 3);
    tick();
    mode = 2'b11;
    tick();
    repeat (8) tick();
    chk("bp_resume_running", halted, 0);
    chk("bp_resume_cyc", cyc_cnt, 20);
    chk("bp_resume_ins", ins_cnt, 5);
    mode = 2'b00;
    tick();
    chk("bp_resume_stop_cause", cause, 3'b001);
    chk("bp_resume_stop_cyc", cyc_cnt, 21);

    do_reset();
    bp_en = 2'b00;
    mode = 2'b11;
    tick();
    repeat (16) tick();
    chk("nobp_running", halted, 0);
    chk("nobp_cyc", cyc_cnt, 16);
    oob = 1'b1;
    tick();
    oob = 1'b0;
    mode = 2'b01;
    repeat (3) tick();
    chk("fault_ce", ce, 0);
    chk("fault_halted", halted, 1);
    chk("fault_cause", cause, 3'b100);
    chk("fault_cyc", cyc_cnt, 17);
    mode = 2'b00;
    tick();
    chk("fault_exit_cause", cause, 3'b100);
    chk("fault_exit_halted", halted, 1);
    mode = 2'b01;
    tick();
    chk("fault_rerun_cause", cause, 3'b000);
    chk("fault_rerun_halted", halted, 0);

    do_reset();
    mode = 2'b01;
    tick();
    repeat (57) tick();
    chk("pre_reset_cyc", cyc_cnt, 57);
    chk("pre_reset_ce", ce, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ce", ce, 0);
    chk("async_reset_cyc", cyc_cnt, 0);
    chk("async_reset_ins", ins_cnt, 0);
    chk("async_reset_halted", halted, 1);
    chk("async_reset_cause", cause, 0);
    rst_n = 1'b1;
    mode = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/datapath_run_ctrl.md
# datapath_run_ctrl

Parametrised run-control unit that sits between the board clock and the multicycle datapath, replacing the fixed-period free-running clock used during bring-up. It produces a clock-enable (`CE`) that gates every datapath register. It supports halt, free-run, single-instruction step and run-to-breakpoint modes, a programmable clock divider, N PC breakpoints and fault halting on out-of-bounds memory access. It also keeps cycle and instruction counters for performance measurement.

## Interface
Parameters:
- `WIDTH`, 16, width of PC.
- `DIV_W`, 8, width of divider select.
- `NUM_BP`, 2, number of PC breakpoints (1..8).
- `CNT_W`, 32, width of cycle and instruction counters.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Mode`  in  2  run mode: 00 HALT, 01 RUN, 10 STEP, 11 RUN_BP.
- `StepReq`  in  1  single-cycle pulse requesting one instruction; only meaningful in STEP mode.
- `DivSel`  in  DIV_W  `CE` asserts once every `DivSel+1` CLK cycles.
- `BpAddr`  in  NUM_BP*WIDTH  breakpoint addresses; entry i is `[i*WIDTH +: WIDTH]`.
- `BpEn`  in  NUM_BP  per-breakpoint enable.
- `PC`  in  WIDTH  current datapath PC.
- `PCWriteOut`  in  1  datapath PC-write strobe; marks the instruction boundary.
- `MemOutOfBounds`  in  1  datapath memory-fault flag.
- `CE`  out  1  datapath clock enable.
- `Halted`  out  1  high in the HALT and FAULT states.
- `HaltCause`  out  3  000 none/reset, 001 user, 010 breakpoint, 011 step done, 100 fault.
- `CycleCount`  out  CNT_W  number of CE cycles issued.
- `InstrCount`  out  CNT_W  number of instructions retired.

## Operation
- States: HALT, RUN, STEP, FAULT.
  - Reset state is HALT.
  - Reset values: `CE`=0, `Halted`=1, `HaltCause`=000, both counters 0, divider count 0, boundary flag 0.
- Divider:
  - `div_cnt` counts from 0 up to `div_lim`.
  - `div_lim` is loaded from `DivSel` on entry to RUN/STEP and on each wrap.
  - `CE` = (state is RUN or STEP) & (`div_cnt`==`div_lim`) & ~`bp_kill`. `CE` is combinational.
  - `div_cnt` clears on entry to RUN/STEP.
- Retire: a retire is a cycle with `CE`=1 and `PCWriteOut`=1.
  - Each CE cycle increments `CycleCount`.
  - Each retire increments `InstrCount`.
  - Both counters wrap modulo 2^CNT_W.
- Boundary flag: set on the cycle after a retire; cleared on the next CE cycle and on leaving HALT.
- `bp_kill` = (state is RUN) & (`Mode`==11) & boundary & (any i with `BpEn[i]` and `PC`==`BpAddr[i]`).
- HALT transitions:
  - `Mode`=01 or 11 → RUN.
  - `Mode`=10 with `StepReq`=1 → STEP.
  - Otherwise stay in HALT.
  - Leaving HALT clears the boundary flag, so resuming from a breakpoint address executes that instruction.
- RUN transitions, in priority order:
  - Fault (`MemOutOfBounds` on a CE cycle) → FAULT, cause 100.
  - `bp_kill` → HALT, cause 010.
  - `Mode` is 00 or 10 → HALT, cause 001.
- STEP transitions, in priority order:
  - Fault → FAULT, cause 100.
  - Retire → HALT, cause 011.
  - `Mode`=00 → HALT, cause 001.
  - `StepReq` is ignored while in STEP; breakpoints are ignored in STEP.
- FAULT: `CE`=0. Leave to HALT only when `Mode`=00; `HaltCause` stays 100 until the next run begins.
- `HaltCause` is cleared to 000 on entry to RUN or STEP.
- Asserting `Reset` mid-run forces HALT and all reset values immediately; `CE` drops asynchronously.

## Timing
- HALT→RUN:
  - `Mode` is sampled at edge k; state is RUN after edge k.
  - First `CE` arrives in the cycle after edge k+`DivSel` (`DivSel`=0: the first RUN cycle).
- Step latency is one instruction (3–5 CE cycles for the current datapath); `Halted` rises on the edge after the retiring CE.
- Breakpoint: the halt takes effect before the first CE of the instruction at the matching PC. No CE is issued at that address.
- Fault: the CE cycle carrying the fault still executes; no further CE is issued. `Halted`=1 after that edge.
- A `DivSel` change while running takes effect at the next divider wrap.

## Test plan
- Reset, then `Mode`=01, `DivSel`=0 → `CE`=1 every cycle from the cycle after the mode edge; after 100 cycles `CycleCount`=100.
- `DivSel`=3, RUN → `CE` high 1 cycle in 4; change `DivSel` to 1 mid-run → the period becomes 2 after the current wrap.
- STEP with PC=0x0000 and a 4-cycle instruction, one `StepReq` → exactly 4 CE pulses, `InstrCount`=1, `Halted`=1, `HaltCause`=011; a second `StepReq` while stepping is ignored.
- RUN_BP with `BpAddr[0]`=0x0006, `BpEn`=01 → halt with `PC`=0x0006, cause 010, no CE at 0x0006. Re-issuing RUN_BP executes 0x0006 and continues; `BpEn`=00 never halts.
- Force `MemOutOfBounds`=1 on a CE cycle → FAULT, cause 100, `CE` held 0 despite `Mode`=01; `Mode`=00 → HALT with cause still 100.
- Drop `Reset` mid-RUN with `CycleCount`=57 → `CE`=0 immediately; counters 0, `Halted`=1, cause 000.
